fft_bfly_sched: RTL

Sequencer for the iterative in-place radix-2 DIT FFT engine.
- Walks all stages and butterflies of an N-point transform.
- Issues, per butterfly, operand addresses a/b to the data RAM and a twiddle index to the sin/cos twiddle ROM.
- Sits between the top-level start/done control and the shared butterfly datapath. Inserts a pipeline-drain barrier between stages so read-after-write hazards cannot occur.

---
 rtl/fft_pkg.sv | 54 +++++
 rtl/fft_bfly_addr_gen.sv | 31 +++
 rtl/fft_bfly_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and helpers for the radix-2 DIT FFT butterfly sequencer.
//   state_e   : sequencer states (LOAD only used when FFT_BITREV_LOAD_EN set)
//   bfly_t    : operand addresses a/b and twiddle index of one butterfly
//   bitrev    : reverse the low 'width' bits of a value
//   bfly_addr : butterfly (stage s, index k) -> a/b/tw mapping
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Fields are wide enough for any practical transform length; users
  // truncate to their own address width.
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] tw;
  } bfly_t;

  function automatic int bitrev(input int value, input int width);
    int r;
    r = 0;
    for (int i = 0; i < width; i++) begin
      if (value[i]) r = r | (1 << (width - 1 - i));
    end
    return r;
  endfunction

  // k enumerates the N/2 butterflies of a stage: the low s bits pick the
  // position inside a group, the remaining bits pick the group.
  function automatic bfly_t bfly_addr(input int s, input int k, input int log2n);
    bfly_t r;
    int    half;
    int    grp;
    int    pos;
    int    base;
    half = 1 << s;
    grp  = k >> s;
    pos  = k & (half - 1);
    base = grp * 2 * half + pos;
    r.a  = 16'(base);
    r.b  = 16'(base + half);
    r.tw = 16'(pos << (log2n - 1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_bfly_addr_gen
// Purely combinational butterfly address mapping.
//   stage_i  : current stage s (0..LOG2N-1)
//   k_i      : butterfly index within the stage (0..N/2-1)
//   addr_a_o : upper operand address
//   addr_b_o : lower operand address (addr_a + 2^s)
//   tw_idx_o : twiddle ROM index (0..N/2-1)
// ---------------------------------------------------------------------------
module fft_bfly_addr_gen
  import fft_pkg::*;
#(
  parameter  int N       = 16,
  localparam int LOG2N   = $clog2(N),
  localparam int STAGE_W = $clog2(LOG2N)
) (
  input  logic [STAGE_W-1:0] stage_i,
  input  logic [LOG2N-2:0]   k_i,
  output logic [LOG2N-1:0]   addr_a_o,
  output logic [LOG2N-1:0]   addr_b_o,
  output logic [LOG2N-2:0]   tw_idx_o
);

  bfly_t map;

  assign map      = bfly_addr(int'(stage_i), int'(k_i), LOG2N);
  assign addr_a_o = LOG2N'(map.a);
  assign addr_b_o = LOG2N'(map.b);
  assign tw_idx_o = (LOG2N-1)'(map.tw);

endmodule

// File: rtl/fft_bfly_sched.sv
// ---------------------------------------------------------------------------
// fft_bfly_sched
// Sequencer for the iterative in-place radix-2 DIT FFT engine. Walks every
// stage and butterfly, issues operand addresses and twiddle index to the
// shared butterfly datapath, and drains the datapath pipeline between
// stages so no stage reads data the previous stage has not written yet.
//
// Ports:
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   start_i          : begin a transform (only looked at in IDLE)
//   busy_o           : high in every state except IDLE
//   done_o           : one-cycle pulse when the transform completes
//   iss_valid_o      : butterfly issue valid
//   iss_ready_i      : datapath accepts the issue
//   addr_a_o/_b_o    : operand addresses (zero when not issuing)
//   tw_idx_o         : twiddle ROM index (zero when not issuing)
//   stage_o          : current stage number
//   last_in_stage_o  : final butterfly of the current stage
//
// Optional feature, macro FFT_BITREV_LOAD_EN: adds a LOAD state between
// IDLE and ISSUE that walks ld_addr_o through bit-reversed order with a
// ld_valid_o / ld_ready_i handshake.
// ---------------------------------------------------------------------------
module fft_bfly_sched
  import fft_pkg::*;
#(
  parameter  int N        = 16,
  parameter  int BFLY_LAT = 3,
  localparam int LOG2N    = $clog2(N),
  localparam int STAGE_W  = $clog2(LOG2N)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               iss_valid_o,
  input  logic               iss_ready_i,
  output logic [LOG2N-1:0]   addr_a_o,
  output logic [LOG2N-1:0]   addr_b_o,
  output logic [LOG2N-2:0]   tw_idx_o,
  output logic [STAGE_W-1:0] stage_o,
  output logic               last_in_stage_o
`ifdef FFT_BITREV_LOAD_EN
  ,
  output logic               ld_valid_o,
  input  logic               ld_ready_i,
  output logic [LOG2N-1:0]   ld_addr_o
`endif
);

  // The drain counter holds at most BFLY_LAT-1; keep at least one bit so
  // the BFLY_LAT=0 and BFLY_LAT=1 builds stay legal.
  localparam int FLUSH_W = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  localparam logic [LOG2N-2:0]   K_LAST = '1;
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2N - 1);

  state_e               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [LOG2N-2:0]     k_q, k_d;
  logic [FLUSH_W-1:0]   flush_q, flush_d;
  logic                 stage_end;

  logic [LOG2N-1:0]     gen_a;
  logic [LOG2N-1:0]     gen_b;
  logic [LOG2N-2:0]     gen_tw;

`ifdef FFT_BITREV_LOAD_EN
  logic [LOG2N-1:0]     ld_cnt_q, ld_cnt_d;
`endif

  // State and counter registers; reset aborts any transform in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      k_q      <= '0;
      flush_q  <= '0;
`ifdef FFT_BITREV_LOAD_EN
      ld_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      k_q      <= k_d;
      flush_q  <= flush_d;
`ifdef FFT_BITREV_LOAD_EN
      ld_cnt_q <= ld_cnt_d;
`endif
    end
  end

  // Next-state logic. stage_end marks the point where a stage is fully
  // drained (end of FLUSH, or the last accepted issue when there is no
  // pipeline to drain) and either moves to the next stage or finishes.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    k_d       = k_q;
    flush_d   = flush_q;
    stage_end = 1'b0;
`ifdef FFT_BITREV_LOAD_EN
    ld_cnt_d  = ld_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          stage_d = '0;
          k_d     = '0;
`ifdef FFT_BITREV_LOAD_EN
          ld_cnt_d = '0;
          state_d  = LOAD;
`else
          state_d = ISSUE;
`endif
        end
      end

`ifdef FFT_BITREV_LOAD_EN
      LOAD: begin
        if (ld_ready_i) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == '1) state_d = ISSUE;
        end
      end
`endif

      ISSUE: begin
        if (iss_ready_i) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) begin
            if (BFLY_LAT > 0) begin
              state_d = FLUSH;
              flush_d = FLUSH_W'(BFLY_LAT - 1);
            end else begin
              stage_end = 1'b1;
            end
          end
        end
      end

      FLUSH: begin
        if (flush_q == '0) stage_end = 1'b1;
        else               flush_d   = flush_q - 1'b1;
      end

      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (stage_end) begin
      if (stage_q == S_LAST) begin
        state_d = DONE;
      end else begin
        stage_d = stage_q + 1'b1;
        k_d     = '0;
        state_d = ISSUE;
      end
    end
  end

  fft_bfly_addr_gen #(.N(N)) u_addr_gen (
    .stage_i  (stage_q),
    .k_i      (k_q),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_idx_o (gen_tw)
  );

  // Addresses are forced to zero outside ISSUE so idle/reset outputs are
  // all-zero rather than the stage-0 mapping of (0,0).
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign iss_valid_o     = (state_q == ISSUE);
  assign last_in_stage_o = iss_valid_o && (k_q == K_LAST);
  assign stage_o         = stage_q;
  assign addr_a_o        = iss_valid_o ? gen_a  : '0;
  assign addr_b_o        = iss_valid_o ? gen_b  : '0;
  assign tw_idx_o        = iss_valid_o ? gen_tw : '0;

`ifdef FFT_BITREV_LOAD_EN
  assign ld_valid_o = (state_q == LOAD);
  assign ld_addr_o  = ld_valid_o ? LOG2N'(bitrev(int'(ld_cnt_q), LOG2N)) : '0;
`endif

endmodule
